// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE squeeze path.
package shake_pkg;

   localparam int unsigned LANE_W              = 64;
   localparam int unsigned NUM_LANES           = 25;
   localparam int unsigned SHAKE128_RATE_LANES = 21;
   localparam int unsigned SHAKE256_RATE_LANES = 17;

   typedef logic [LANE_W-1:0] lane_t;
   typedef lane_t [4:0][4:0]  state_t;

   typedef enum logic [2:0] {IDLE, WAIT, STREAM, PERM, DONE} sq_state_e;

endpackage

// File: rtl/shake_squeeze_if.sv
// Output word stream of the squeeze engine (valid/ready).
// SHAKE_SQUEEZE_LAST_EN adds the dout_last end-of-stream marker.
interface shake_squeeze_if;
   import shake_pkg::*;

   lane_t dout;
   logic  dout_valid;
   logic  dout_ready;
`ifdef SHAKE_SQUEEZE_LAST_EN
   logic  dout_last;

   modport master (output dout, output dout_valid, output dout_last, input dout_ready);
   modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);
`else
   modport master (output dout, output dout_valid, input dout_ready);
   modport slave  (input dout, input dout_valid, output dout_ready);
`endif

endinterface

// File: rtl/shake_lane_sel.sv
// Maps a linear lane index n to snapshot[n%5][n/5]; indices past 24 yield zero.
module shake_lane_sel
   import shake_pkg::*;
(
   input  state_t     snapshot,
   input  logic [4:0] idx,
   output lane_t      lane_c
);

   logic [2:0] x_c;
   logic [2:0] y_c;

   always_comb begin
      x_c    = 3'(idx % 5'd5);
      y_c    = 3'(idx / 5'd5);
      lane_c = '0;
      if (idx < 5'(NUM_LANES)) lane_c = snapshot[x_c][y_c];
   end

endmodule

// File: rtl/shake_squeeze.sv
// Squeeze end of the SHAKE sponge: streams rate lanes of a permuted state, asks for more permutations.
// SHAKE_SQUEEZE_LAST_EN adds sq.dout_last, high with the final word.
module shake_squeeze
   import shake_pkg::*;
#(
   parameter int unsigned RATE_LANES = SHAKE128_RATE_LANES,
   parameter int unsigned LEN_W      = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] out_len,
   input  state_t           state,
   input  logic             state_vld,
   output logic             perm_req,
   shake_squeeze_if.master  sq,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CNT_W     = 5;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATE_LANES - 1);

   sq_state_e        fsm;
   logic [CNT_W-1:0] lane_cnt;
   logic [LEN_W-1:0] remaining;
   state_t           snapshot;
   lane_t            nxt_lane_c;
   logic [CNT_W-1:0] nxt_idx_c;
   logic             xfer_c;

   assign xfer_c    = sq.dout_valid && sq.dout_ready;
   assign nxt_idx_c = lane_cnt + CNT_W'(1);

   // dout is preloaded with the following lane so each transfer can advance in one cycle
   shake_lane_sel u_lane_sel (
      .snapshot (snapshot),
      .idx      (nxt_idx_c),
      .lane_c   (nxt_lane_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm           <= IDLE;
         lane_cnt      <= '0;
         remaining     <= '0;
         snapshot      <= '0;
         perm_req      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         sq.dout       <= '0;
         sq.dout_valid <= 1'b0;
`ifdef SHAKE_SQUEEZE_LAST_EN
         sq.dout_last  <= 1'b0;
`endif
      end else begin
         perm_req <= 1'b0;
         done     <= 1'b0;
         unique case (fsm)
            IDLE: begin
               if (start) begin
                  busy      <= 1'b1;
                  remaining <= out_len;
                  if (out_len != '0) begin
                     fsm <= WAIT;
                  end else begin
                     fsm  <= DONE;
                     done <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (state_vld) begin
                  snapshot      <= state;
                  lane_cnt      <= '0;
                  sq.dout       <= state[0][0];
                  sq.dout_valid <= 1'b1;
`ifdef SHAKE_SQUEEZE_LAST_EN
                  sq.dout_last  <= (remaining == LEN_W'(1));
`endif
                  fsm           <= STREAM;
               end
            end
            STREAM: begin
               if (xfer_c) begin
                  remaining <= remaining - LEN_W'(1);
                  lane_cnt  <= nxt_idx_c;
                  if (remaining == LEN_W'(1)) begin
                     sq.dout_valid <= 1'b0;
`ifdef SHAKE_SQUEEZE_LAST_EN
                     sq.dout_last  <= 1'b0;
`endif
                     done          <= 1'b1;
                     fsm           <= DONE;
                  end else if (lane_cnt == LAST_LANE) begin
                     sq.dout_valid <= 1'b0;
                     perm_req      <= 1'b1;
                     fsm           <= PERM;
                  end else begin
                     sq.dout       <= nxt_lane_c;
`ifdef SHAKE_SQUEEZE_LAST_EN
                     sq.dout_last  <= (remaining == LEN_W'(2));
`endif
                  end
               end
            end
            PERM: fsm <= WAIT;
            DONE: begin
               busy <= 1'b0;
               fsm  <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule
